stage_scheduler: RTL and testbench

Frame-level sequencer for the 8x8 drops game. It runs the three processing stages (input sampling, drop/action update, matrix display) in a fixed order, using level enables and done handshakes. It also throttles the action stage to a programmable game speed, guards every stage with a watchdog timeout, supports pausing at frame boundaries, and exposes frame-count and status outputs. It sits in the top level between the stage blocks and replaces the ad-hoc enable FSM.

---
 rtl/stage_scheduler.sv | 245 ++++++++++++++++++++++++
 tb/tb_stage_scheduler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_scheduler.sv
// stage_scheduler
// Frame-level sequencer for the 8x8 drops game. Runs the input, action and
// display stages in a fixed order using level enables and done handshakes,
// throttles the action stage to a programmable game speed, guards every stage
// with a watchdog, pauses at frame boundaries and reports frame/status.
//
// Ports:
//   clk_i      - clock, all state changes on its rising edge
//   rst_i      - asynchronous active-high reset
//   pause_i    - pause request, sampled only at frame boundaries
//   speed_i    - frames skipped between action steps (0 = every frame)
//   d_inp_i    - done from the input stage
//   d_act_i    - done from the action stage
//   d_disp_i   - done from the display stage
//   e_inp_o    - input stage enable
//   e_act_o    - action stage enable
//   e_disp_o   - display stage enable
//   stage_o    - 0 idle/paused, 1 input, 2 action, 3 display
//   frame_o    - completed frame count, wraps at 16 bits
//   timeout_o  - sticky watchdog flag, cleared only by reset
//   paused_o   - high while paused
module stage_scheduler #(
  parameter int TIMEOUT = 200,
  parameter int TO_W    = 8,
  parameter int SPD_W   = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pause_i,
  input  logic [SPD_W-1:0] speed_i,
  input  logic             d_inp_i,
  input  logic             d_act_i,
  input  logic             d_disp_i,
  output logic             e_inp_o,
  output logic             e_act_o,
  output logic             e_disp_o,
  output logic [1:0]       stage_o,
  output logic [15:0]      frame_o,
  output logic             timeout_o,
  output logic             paused_o
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INP    = 3'd1,
    ST_ACT    = 3'd2,
    ST_DISP   = 3'd3,
    ST_PAUSED = 3'd4
  } state_t;

  state_t             state_r;
  state_t             state_n_s;
  logic [TO_W-1:0]    wd_cnt_r;
  logic [TO_W-1:0]    wd_n_s;
  logic [SPD_W-1:0]   skip_cnt_r;
  logic [SPD_W-1:0]   skip_n_s;
  logic [15:0]        frame_r;
  logic [15:0]        frame_n_s;
  logic               timeout_r;
  logic               timeout_n_s;

  logic               e_inp_r;
  logic               e_act_r;
  logic               e_disp_r;
  logic [1:0]         stage_r;
  logic               paused_r;

  logic               e_inp_n_s;
  logic               e_act_n_s;
  logic               e_disp_n_s;
  logic [1:0]         stage_n_s;
  logic               paused_n_s;

  logic               done_s;
  logic               in_stage_s;
  logic               honour_s;
  logic               expire_s;
  logic               complete_s;

  // Select the done of the active stage and evaluate completion.
  // The watchdog count is zero only in the entry cycle, so it doubles as the
  // entry-cycle marker that masks a stale done left over from the last frame.
  always_comb begin
    done_s     = 1'b0;
    in_stage_s = 1'b0;
    case (state_r)
      ST_INP: begin
        done_s     = d_inp_i;
        in_stage_s = 1'b1;
      end
      ST_ACT: begin
        done_s     = d_act_i;
        in_stage_s = 1'b1;
      end
      ST_DISP: begin
        done_s     = d_disp_i;
        in_stage_s = 1'b1;
      end
      default: begin
        done_s     = 1'b0;
        in_stage_s = 1'b0;
      end
    endcase
    honour_s   = done_s & (wd_cnt_r != {TO_W{1'b0}});
    expire_s   = in_stage_s & (wd_cnt_r == TO_W'(TIMEOUT - 1));
    complete_s = honour_s | expire_s;
  end

  // Next-state, throttle, frame counter and sticky watchdog flag.
  always_comb begin
    state_n_s   = state_r;
    skip_n_s    = skip_cnt_r;
    frame_n_s   = frame_r;
    timeout_n_s = timeout_r;

    // A real done on the expiry edge wins, so the flag is not raised then.
    if (expire_s && !honour_s) begin
      timeout_n_s = 1'b1;
    end else begin
      timeout_n_s = timeout_r;
    end

    case (state_r)
      ST_IDLE: begin
        state_n_s = ST_INP;
      end
      ST_INP: begin
        if (complete_s) begin
          if (skip_cnt_r >= speed_i) begin
            state_n_s = ST_ACT;
            skip_n_s  = {SPD_W{1'b0}};
          end else begin
            state_n_s = ST_DISP;
            skip_n_s  = skip_cnt_r + SPD_W'(1);
          end
        end else begin
          state_n_s = ST_INP;
        end
      end
      ST_ACT: begin
        if (complete_s) begin
          state_n_s = ST_DISP;
        end else begin
          state_n_s = ST_ACT;
        end
      end
      ST_DISP: begin
        if (complete_s) begin
          frame_n_s = frame_r + 16'd1;
          if (pause_i) begin
            state_n_s = ST_PAUSED;
          end else begin
            state_n_s = ST_INP;
          end
        end else begin
          state_n_s = ST_DISP;
        end
      end
      ST_PAUSED: begin
        if (!pause_i) begin
          state_n_s = ST_INP;
        end else begin
          state_n_s = ST_PAUSED;
        end
      end
      default: begin
        state_n_s = ST_IDLE;
      end
    endcase

    // Watchdog restarts on every state change and only runs inside a stage.
    if (state_n_s != state_r) begin
      wd_n_s = {TO_W{1'b0}};
    end else if (in_stage_s) begin
      wd_n_s = wd_cnt_r + TO_W'(1);
    end else begin
      wd_n_s = {TO_W{1'b0}};
    end
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    e_inp_n_s  = 1'b0;
    e_act_n_s  = 1'b0;
    e_disp_n_s = 1'b0;
    stage_n_s  = 2'd0;
    paused_n_s = 1'b0;
    case (state_n_s)
      ST_INP: begin
        e_inp_n_s = 1'b1;
        stage_n_s = 2'd1;
      end
      ST_ACT: begin
        e_act_n_s = 1'b1;
        stage_n_s = 2'd2;
      end
      ST_DISP: begin
        e_disp_n_s = 1'b1;
        stage_n_s  = 2'd3;
      end
      ST_PAUSED: begin
        paused_n_s = 1'b1;
      end
      default: begin
        stage_n_s = 2'd0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r    <= ST_IDLE;
      wd_cnt_r   <= {TO_W{1'b0}};
      skip_cnt_r <= {SPD_W{1'b0}};
      frame_r    <= 16'd0;
      timeout_r  <= 1'b0;
      e_inp_r    <= 1'b0;
      e_act_r    <= 1'b0;
      e_disp_r   <= 1'b0;
      stage_r    <= 2'd0;
      paused_r   <= 1'b0;
    end else begin
      state_r    <= state_n_s;
      wd_cnt_r   <= wd_n_s;
      skip_cnt_r <= skip_n_s;
      frame_r    <= frame_n_s;
      timeout_r  <= timeout_n_s;
      e_inp_r    <= e_inp_n_s;
      e_act_r    <= e_act_n_s;
      e_disp_r   <= e_disp_n_s;
      stage_r    <= stage_n_s;
      paused_r   <= paused_n_s;
    end
  end

  assign e_inp_o   = e_inp_r;
  assign e_act_o   = e_act_r;
  assign e_disp_o  = e_disp_r;
  assign stage_o   = stage_r;
  assign frame_o   = frame_r;
  assign timeout_o = timeout_r;
  assign paused_o  = paused_r;

endmodule

// File: tb/tb_stage_scheduler.sv
// tb_stage_scheduler
// Self-checking bench for stage_scheduler: directed scenarios plus a random
// phase, all compared cycle by cycle against a behavioural frame model.
module tb_stage_scheduler;

  localparam int TIMEOUT = 10;
  localparam int TO_W    = 8;
  localparam int SPD_W   = 4;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             pause_i = 1'b0;
  logic [SPD_W-1:0] speed_i = 4'd0;
  logic             d_inp_i = 1'b0;
  logic             d_act_i = 1'b0;
  logic             d_disp_i = 1'b0;
  logic             e_inp_o;
  logic             e_act_o;
  logic             e_disp_o;
  logic [1:0]       stage_o;
  logic [15:0]      frame_o;
  logic             timeout_o;
  logic             paused_o;

  stage_scheduler #(.TIMEOUT(TIMEOUT), .TO_W(TO_W), .SPD_W(SPD_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pause_i(pause_i), .speed_i(speed_i),
    .d_inp_i(d_inp_i), .d_act_i(d_act_i), .d_disp_i(d_disp_i),
    .e_inp_o(e_inp_o), .e_act_o(e_act_o), .e_disp_o(e_disp_o),
    .stage_o(stage_o), .frame_o(frame_o), .timeout_o(timeout_o),
    .paused_o(paused_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: which stage is running, how long it has run, frames.
  bit m_idle;
  bit m_paused;
  int m_stage;
  int m_age;
  int m_frames;
  int m_skip;
  bit m_to;

  // Stage-block emulation.
  int dly[3];
  int en_age[3];
  int last_run[3];
  bit stale_disp = 1'b0;
  bit rnd_mode = 1'b0;
  int done_pct = 30;

  // Throttle recording.
  bit       thr_rec = 1'b0;
  int       thr_base = 0;
  logic [8:0] act_mask = 9'd0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_idle = 1'b1; m_paused = 1'b0; m_stage = 0; m_age = 0;
    m_frames = 0; m_skip = 0; m_to = 1'b0;
  endtask

  task automatic model_step();
    bit dn, hon, expd;
    if (m_idle) begin
      m_idle = 1'b0; m_stage = 1; m_age = 0;
    end else if (m_paused) begin
      if (!pause_i) begin
        m_paused = 1'b0; m_stage = 1; m_age = 0;
      end
    end else begin
      dn   = (m_stage == 1) ? d_inp_i : (m_stage == 2) ? d_act_i : d_disp_i;
      hon  = dn && (m_age >= 1);
      expd = (m_age == TIMEOUT - 1);
      if (hon || expd) begin
        if (!hon) m_to = 1'b1;
        if (m_stage == 1) begin
          if (m_skip >= int'(speed_i)) begin m_stage = 2; m_skip = 0; end
          else begin m_stage = 3; m_skip = m_skip + 1; end
        end else if (m_stage == 2) begin
          m_stage = 3;
        end else begin
          m_frames = (m_frames + 1) % 65536;
          if (pause_i) begin m_paused = 1'b1; m_stage = 0; end
          else m_stage = 1;
        end
        m_age = 0;
      end else begin
        m_age = m_age + 1;
      end
    end
  endtask

  function automatic logic [31:0] exp_vec();
    logic [22:0] v;
    v = {m_stage == 1, m_stage == 2, m_stage == 3, 2'(m_stage), m_paused, m_to, 16'(m_frames)};
    return {9'd0, v};
  endfunction

  function automatic logic [31:0] obs_vec();
    return {9'd0, e_inp_o, e_act_o, e_disp_o, stage_o, paused_o, timeout_o, frame_o};
  endfunction

  task automatic drive_inputs();
    if (rnd_mode) begin
      d_inp_i  = ($urandom_range(0, 99) < done_pct);
      d_act_i  = ($urandom_range(0, 99) < done_pct);
      d_disp_i = ($urandom_range(0, 99) < done_pct);
    end else begin
      d_inp_i  = e_inp_o && (en_age[0] > dly[0]);
      d_act_i  = e_act_o && (en_age[1] > dly[1]);
      d_disp_i = stale_disp ? 1'b1 : (e_disp_o && (en_age[2] > dly[2]));
    end
  endtask

  // One clock: drive, edge, advance model, sample 1 time unit later, compare.
  task automatic cycle();
    logic [2:0] en;
    drive_inputs();
    @(posedge clk_i);
    if (!rst_i) model_step();
    #1;
    check_value("cyc", obs_vec(), exp_vec());
    if (thr_rec && e_act_o && (m_frames - thr_base) < 9 && (m_frames - thr_base) >= 0)
      act_mask[m_frames - thr_base] = 1'b1;
    en = {e_disp_o, e_act_o, e_inp_o};
    for (int i = 0; i < 3; i++) begin
      if (en[i]) en_age[i]++;
      else begin
        if (en_age[i] != 0) last_run[i] = en_age[i];
        en_age[i] = 0;
      end
    end
  endtask

  task automatic apply_reset();
    #2;
    rst_i = 1'b1;
    #1;
    model_reset();
    check_value("async_rst", obs_vec(), exp_vec());
    for (int i = 0; i < 3; i++) en_age[i] = 0;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic run_frames(input int n);
    int target;
    target = m_frames + n;
    for (int i = 0; i < 5000 && m_frames != target; i++) cycle();
    check_value("frames_reached", 32'(frame_o), 32'(target));
  endtask

  task automatic wait_stage(input int s);
    for (int i = 0; i < 200 && !(m_stage == s && !m_paused && !m_idle); i++) cycle();
    check_value("stage_reached", 32'(stage_o), 32'(s));
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin dly[i] = 3; en_age[i] = 0; last_run[i] = 0; end
    #1;
    apply_reset();

    // Basic sequencing.
    speed_i = 4'd0;
    cycle();
    check_value("edge0_inp", 32'(e_inp_o), 32'd1);
    run_frames(3);
    check_value("basic_frames", 32'(frame_o), 32'd3);
    check_value("basic_to", 32'(timeout_o), 32'd0);

    // Throttle: two slow frames bank two skips, then speed 2 for nine frames.
    apply_reset();
    speed_i = 4'd15;
    run_frames(2);
    speed_i = 4'd2;
    thr_base = m_frames;
    act_mask = 9'd0;
    thr_rec = 1'b1;
    run_frames(9);
    thr_rec = 1'b0;
    check_value("thr_mask", 32'(act_mask), 32'h049);
    check_value("thr_frames", 32'(frame_o), 32'd11);
    speed_i = 4'd0;

    // Watchdog: done coinciding with expiry, then done stuck low.
    apply_reset();
    dly[1] = 9;
    run_frames(1);
    check_value("wd_coinc_len", 32'(last_run[1]), 32'd10);
    check_value("wd_coinc_to", 32'(timeout_o), 32'd0);
    dly[1] = 1000;
    run_frames(1);
    check_value("wd_len", 32'(last_run[1]), 32'd10);
    check_value("wd_to", 32'(timeout_o), 32'd1);
    dly[1] = 3;
    run_frames(2);
    check_value("wd_sticky", 32'(timeout_o), 32'd1);

    // Stale done on display.
    apply_reset();
    stale_disp = 1'b1;
    run_frames(2);
    check_value("stale_len", 32'(last_run[2]), 32'd2);
    stale_disp = 1'b0;

    // Pause raised mid-action.
    apply_reset();
    run_frames(1);
    wait_stage(2);
    cycle();
    pause_i = 1'b1;
    begin
      int f0;
      f0 = m_frames;
      for (int i = 0; i < 200 && !m_paused; i++) cycle();
      check_value("pause_frame", 32'(frame_o), 32'(f0 + 1));
    end
    for (int i = 0; i < 20; i++) begin
      cycle();
      check_value("pause_hold", {28'd0, e_inp_o, e_act_o, e_disp_o, paused_o}, 32'h1);
    end
    pause_i = 1'b0;
    cycle();
    check_value("pause_exit", 32'(e_inp_o), 32'd1);

    // Reset in the middle of an action stage at frame 5.
    apply_reset();
    run_frames(5);
    wait_stage(2);
    cycle();
    check_value("pre_rst_frame", 32'(frame_o), 32'd5);
    apply_reset();
    check_value("rst_act_low", 32'(e_act_o), 32'd0);
    cycle();
    check_value("rst_edge0", {30'd0, e_inp_o, stage_o == 2'd1}, 32'h3);

    // Random phase.
    rnd_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) done_pct = $urandom_range(5, 60);
      if ($urandom_range(0, 29) == 0) pause_i = ~pause_i;
      if ($urandom_range(0, 49) == 0) speed_i = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 799) == 0) apply_reset();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
